// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage for the educational RV32 core. Holds the
//             fetch PC, issues word requests to instruction memory with up to
//             FIFO_DEPTH requests in flight, buffers in-order responses with
//             their PCs and hands them to decode over valid/ready. Branch and
//             jump redirects flush everything fetched on the wrong path.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             pc_sel                - 00 PC_PLUS_4, 01 PC_BRANCH, 10 PC_JUMP,
//                                     11 behaves as PC_PLUS_4
//             branch_target         - redirect target for PC_BRANCH
//             jump_target           - redirect target for PC_JUMP
//             imem_req_*            - word fetch request (valid/ready/addr)
//             imem_rsp_*            - in-order fetch response (valid/data)
//             instr_valid/ready     - handshake towards decode
//             instr_data/instr_pc   - instruction and PC at buffer head
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc
);

    localparam logic [1:0] c_PC_PLUS_4 = 2'b00;
    localparam logic [1:0] c_PC_BRANCH = 2'b01;
    localparam logic [1:0] c_PC_JUMP   = 2'b10;

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W1 = CNT_W + 1;

    localparam logic [PTR_W-1:0]  c_PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W1-1:0] c_DEPTH      = CNT_W1'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]   c_ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0]   c_PC_STEP    = XLEN'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  r_fetch_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop;

    logic [XLEN-1:0]  r_tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_tag_wr;
    logic [PTR_W-1:0] r_tag_rd;

    logic [XLEN-1:0]  r_out_pc   [FIFO_DEPTH];
    logic [31:0]      r_out_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_out_wr;
    logic [PTR_W-1:0] r_out_rd;
    logic [CNT_W-1:0] r_out_count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic              w_redirect;
    logic [XLEN-1:0]   w_target;
    logic              w_pop;
    logic              w_accept;
    logic              w_rsp_keep;
    logic [CNT_W1-1:0] w_used;
    logic [XLEN-1:0]   w_tag_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_redirect = 1'b0;
        w_target   = branch_target;
        case (pc_sel)
            c_PC_BRANCH: begin
                w_redirect = 1'b1;
                w_target   = branch_target;
            end
            c_PC_JUMP: begin
                w_redirect = 1'b1;
                w_target   = jump_target;
            end
            c_PC_PLUS_4: w_redirect = 1'b0;
            default:     w_redirect = 1'b0;
        endcase
    end

    assign instr_valid = (r_out_count != '0);
    assign instr_data  = r_out_data[r_out_rd];
    assign instr_pc    = r_out_pc[r_out_rd];
    assign w_pop       = instr_valid && instr_ready;
    assign w_tag_head  = r_tag_mem[r_tag_rd];

    // Credits: every slot is either in flight or buffered. An entry leaving
    // to decode this cycle frees its slot immediately (combinational from
    // instr_ready) so a depth-2 buffer sustains one fetch per cycle at L=1.
    assign w_used = {1'b0, r_outstanding} + {1'b0, r_out_count}
                  - {{CNT_W{1'b0}}, w_pop};

    // rst_n gates the request so nothing is offered while held in reset.
    assign imem_req_valid = rst_n && !w_redirect && (w_used < c_DEPTH);
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // A response arriving in a redirect cycle is already stale.
    assign w_rsp_keep = imem_rsp_valid && !w_redirect && (r_drop == '0);

    // ------------------------------------------------------------------
    // Fetch PC, outstanding and drop counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            if (w_redirect) begin
                r_fetch_pc <= w_target & c_ALIGN_MASK;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + c_PC_STEP;
            end

            case ({w_accept, imem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            // Everything still in flight after this cycle belongs to the
            // wrong path; a coincident response is discarded directly.
            if (w_redirect) begin
                r_drop <= r_outstanding - CNT_W'(imem_rsp_valid);
            end else if (imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // PC tag FIFO: one entry per request in flight
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_tag_mem[i] <= '0;
            end
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_accept) begin
                r_tag_mem[r_tag_wr] <= r_fetch_pc;
                r_tag_wr            <= ptr_inc(r_tag_wr);
            end
            if (imem_rsp_valid) begin
                r_tag_rd <= ptr_inc(r_tag_rd);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO of {pc, instr}; the head is presented to decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_out_pc[i]   <= '0;
                r_out_data[i] <= '0;
            end
            r_out_wr    <= '0;
            r_out_rd    <= '0;
            r_out_count <= '0;
        end else if (w_redirect) begin
            // A pop in this cycle has already completed its handshake.
            r_out_wr    <= '0;
            r_out_rd    <= '0;
            r_out_count <= '0;
        end else begin
            if (w_rsp_keep) begin
                r_out_pc[r_out_wr]   <= w_tag_head;
                r_out_data[r_out_wr] <= imem_rsp_data;
                r_out_wr             <= ptr_inc(r_out_wr);
            end
            if (w_pop) begin
                r_out_rd <= ptr_inc(r_out_rd);
            end
            case ({w_rsp_keep, w_pop})
                2'b10:   r_out_count <= r_out_count + 1'b1;
                2'b01:   r_out_count <= r_out_count - 1'b1;
                default: r_out_count <= r_out_count;
            endcase
        end
    end

endmodule
`default_nettype wire
